// File: rtl/seg_mode_controller.sv
// seg_mode_controller
// -------------------
// Seven-segment display mode selector. Two raw active-low push-buttons step
// the mode index forward / backward (wrapping at both ends); a lock input
// discards presses. Each button is synchronised (2 flops) and debounced.
// The digit bank and banner glyph for the current mode are registered out.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   btn_next_n    raw "next" button, active-low, asynchronous
//   btn_prev_n    raw "previous" button, active-low, asynchronous
//   lock          when high, press events are discarded (not queued)
//   mode_seg_in   packed digit banks, mode m at [(m+1)*DIGITS*SEG_W-1 -: DIGITS*SEG_W]
//   banner_in     packed banner glyphs, glyph m at [(m+1)*SEG_W-1 -: SEG_W]
//   seg_out       registered digit bank of the current mode (all ones = blank)
//   banner_out    registered banner glyph of the current mode
//   mode          current mode index
//   mode_changed  one-cycle pulse, high in the first cycle a new mode is shown
//
// Handshake: there is no valid/ready pair; mode_changed acts as a strobe
// qualifying the first cycle of a new value on mode.
module seg_mode_controller #(
    parameter int N_MODES    = 3,
    parameter int DIGITS     = 2,
    parameter int SEG_W      = 8,
    parameter int DEB_CYCLES = 50000,
    localparam int MODE_W    = $clog2(N_MODES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             btn_next_n,
    input  logic                             btn_prev_n,
    input  logic                             lock,
    input  logic [N_MODES*DIGITS*SEG_W-1:0]  mode_seg_in,
    input  logic [N_MODES*SEG_W-1:0]         banner_in,
    output logic [DIGITS*SEG_W-1:0]          seg_out,
    output logic [SEG_W-1:0]                 banner_out,
    output logic [MODE_W-1:0]                mode,
    output logic                             mode_changed
);

    localparam int BANK_W = DIGITS * SEG_W;
    localparam int CNT_W  = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(N_MODES - 1);

    // Index 0 = next button, index 1 = prev button.
    logic [1:0]       raw_n;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       press;

    assign raw_n = {btn_prev_n, btn_next_n};

    // Synchroniser and debounce. Everything resets to "released" so the
    // first deassertion of reset can never look like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_MAX) begin
                    stable[b] <= sync2[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    // Press event: high in the cycle the stable level is about to go 1->0.
    // Release transitions never produce an event.
    always_comb begin
        press = '0;
        for (int b = 0; b < 2; b++) begin
            press[b] = stable[b] & ~sync2[b] & (cnt[b] == CNT_MAX);
        end
    end

    // Next-mode logic. Simultaneous next+prev cancel; lock drops the event.
    logic [MODE_W-1:0] mode_next;
    logic              changed_next;

    always_comb begin
        mode_next    = mode;
        changed_next = 1'b0;
        if (!lock && (press[0] ^ press[1])) begin
            changed_next = 1'b1;
            if (press[0]) begin
                // ">=" also recovers an out-of-range index back to 0.
                mode_next = (mode >= MODE_LAST) ? '0 : mode + 1'b1;
            end else begin
                mode_next = (mode == '0) ? MODE_LAST : mode - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode         <= '0;
            mode_changed <= 1'b0;
        end else begin
            mode         <= mode_next;
            mode_changed <= changed_next;
        end
    end

    // Output selection: an index with no matching bank blanks the display.
    logic [BANK_W-1:0] bank_sel;
    logic [SEG_W-1:0]  glyph_sel;

    always_comb begin
        bank_sel  = '1;
        glyph_sel = '1;
        for (int m = 0; m < N_MODES; m++) begin
            if (mode == MODE_W'(m)) begin
                bank_sel  = mode_seg_in[m*BANK_W +: BANK_W];
                glyph_sel = banner_in[m*SEG_W +: SEG_W];
            end
        end
    end

    // Refreshed every cycle so live changes on the bank inputs show through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out    <= '1;
            banner_out <= '1;
        end else begin
            seg_out    <= bank_sel;
            banner_out <= glyph_sel;
        end
    end

endmodule
